da_dct_sequencer: RTL and testbench

Bit-serial distributed-arithmetic (DA) sequencer for one DCT output coefficient in the DCT+RLE compression path. It accepts four signed EEG samples and walks their bit-slices LSB-first, one bit per cycle. Each slice drives the 8-entry coefficient ROM address plus a bank select, and the block shift-accumulates the returned partial sums into a signed coefficient. It sits between the sample buffer upstream and the RLE encoder downstream, and owns the ROM's chip select.

---
 rtl/dct_pkg.sv | 15 +
 rtl/da_slice_shifter.sv | 34 +++
 rtl/da_dct_sequencer.sv | 100 ++++++++++
 tb/tb_da_dct_sequencer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/dct_pkg.sv
// Shared widths, state encoding and scheduling constants for the DA DCT path.
package dct_pkg;

    localparam int DCT_DATA_W = 12;
    localparam int DCT_ROM_W  = 17;
    localparam int DCT_ACC_W  = DCT_ROM_W + DCT_DATA_W;
    localparam int DCT_ROWS   = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } dct_state_e;

endpackage

// File: rtl/da_slice_shifter.sv
// Four-lane arithmetic right shifter; bit 0 of each lane is the current DA slice.
module da_slice_shifter #(
    parameter int DATA_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic              i_shift,
    input  logic [DATA_W-1:0] i_x0,
    input  logic [DATA_W-1:0] i_x1,
    input  logic [DATA_W-1:0] i_x2,
    input  logic [DATA_W-1:0] i_x3,
    output logic [3:0]        o_slice
);

    logic [DATA_W-1:0] r_lane [4];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) r_lane[i] <= '0;
        end else if (i_load) begin
            r_lane[0] <= i_x0;
            r_lane[1] <= i_x1;
            r_lane[2] <= i_x2;
            r_lane[3] <= i_x3;
        end else if (i_shift) begin
            for (int i = 0; i < 4; i++)
                r_lane[i] <= {r_lane[i][DATA_W-1], r_lane[i][DATA_W-1:1]};
        end
    end

    assign o_slice = {r_lane[0][0], r_lane[1][0], r_lane[2][0], r_lane[3][0]};

endmodule

// File: rtl/da_dct_sequencer.sv
// Bit-serial DA sequencer: walks four samples LSB-first and accumulates ROM partial sums.
//  state | meaning
//  IDLE  | ready for a sample set, ROM deselected
//  RUN   | one bit-slice per cycle on the ROM, accumulating
//  DONE  | coefficient valid, waiting for out_ready
module da_dct_sequencer
    import dct_pkg::*;
#(
    parameter int DATA_W = DCT_DATA_W,
    parameter int ROM_W  = DCT_ROM_W,
    parameter int ACC_W  = ROM_W + DATA_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       x0,
    input  logic [DATA_W-1:0]       x1,
    input  logic [DATA_W-1:0]       x2,
    input  logic [DATA_W-1:0]       x3,
    output logic                    rom_cs,
    output logic [2:0]              rom_addr,
    output logic                    rom_bank,
    input  logic signed [ROM_W-1:0] rom_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] out_data
);

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_RUN  = RUN;
    localparam logic [1:0] S_DONE = DONE;
    localparam int         CNT_W  = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    logic [1:0]              r_state;
    logic [CNT_W-1:0]        r_bit_cnt;
    logic signed [ACC_W-1:0] r_acc;

    logic                    w_run;
    logic                    w_accept;
    logic                    w_last;
    logic [3:0]              w_slice;
    logic signed [ACC_W-1:0] w_rom_ext;
    logic signed [ACC_W-1:0] w_term;

    assign w_run     = (r_state == S_RUN);
    assign w_accept  = in_valid && (r_state == S_IDLE);
    assign w_last    = (r_bit_cnt == LAST_BIT);
    assign w_rom_ext = {{(ACC_W-ROM_W){rom_data[ROM_W-1]}}, rom_data};
    assign w_term    = w_rom_ext <<< r_bit_cnt;

    da_slice_shifter #(.DATA_W(DATA_W)) u_shifter (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_accept),
        .i_shift (w_run),
        .i_x0    (x0),
        .i_x1    (x1),
        .i_x2    (x2),
        .i_x3    (x3),
        .o_slice (w_slice)
    );

    // The MSB slice carries negative weight in two's complement, hence the subtract.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_bit_cnt <= '0;
            r_acc     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_acc     <= '0;
                        r_bit_cnt <= '0;
                        r_state   <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_acc     <= w_last ? (r_acc - w_term) : (r_acc + w_term);
                    r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                    if (w_last) r_state <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign rom_cs    = w_run;
    assign rom_bank  = w_run & w_slice[3];
    assign rom_addr  = w_run ? w_slice[2:0] : 3'b000;
    assign out_valid = (r_state == S_DONE);
    assign out_data  = r_acc;

endmodule

// File: tb/tb_da_dct_sequencer.sv
// Directed vector table plus hand-written corner sequences for da_dct_sequencer.
module tb_da_dct_sequencer;

    localparam int DW = 12;
    localparam int RW = 17;
    localparam int AW = RW + DW;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [DW-1:0]        x0 = '0, x1 = '0, x2 = '0, x3 = '0;
    logic                 rom_cs;
    logic [2:0]           rom_addr;
    logic                 rom_bank;
    logic signed [RW-1:0] rom_data;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic signed [AW-1:0] out_data;

    int rom_mode = 0;
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    da_dct_sequencer dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .x0(x0), .x1(x1), .x2(x2), .x3(x3),
        .rom_cs(rom_cs), .rom_addr(rom_addr), .rom_bank(rom_bank), .rom_data(rom_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    // ROM contents: mode 0 constant 1, mode 1 returns the bank bit, mode 2 a full table.
    function automatic logic signed [RW-1:0] rom_val(int mode, logic bank, logic [2:0] addr);
        logic signed [RW-1:0] t0 [8];
        logic signed [RW-1:0] t1 [8];
        t0 = '{17'sh133E, 17'sh0A21, -17'sh0512, 17'sh1F00, 17'sh0333, -17'sh0C00, 17'sh07FF, 17'sh0100};
        t1 = '{17'sh0111, -17'sh1234, 17'sh0ABC, 17'sh0042, -17'sh0777, 17'sh1500, -17'sh0099, 17'sh0250};
        case (mode)
            0: return 17'sd1;
            1: return bank ? 17'sd1 : 17'sd0;
            default: return bank ? t1[addr] : t0[addr];
        endcase
    endfunction

    always_comb rom_data = rom_val(rom_mode, rom_bank, rom_addr);

    function automatic longint golden(int mode, logic [DW-1:0] a, logic [DW-1:0] b,
                                      logic [DW-1:0] c, logic [DW-1:0] d);
        longint acc = 0;
        longint r;
        for (int k = 0; k < DW; k++) begin
            r = longint'(rom_val(mode, a[k], {b[k], c[k], d[k]}));
            if (k == DW-1) acc -= r * (longint'(1) << k);
            else           acc += r * (longint'(1) << k);
        end
        return acc;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_in_ready"}, longint'(in_ready), 1);
        check({name, "_rom_cs"}, longint'(rom_cs), 0);
        check({name, "_rom_addr"}, longint'(rom_addr), 0);
        check({name, "_rom_bank"}, longint'(rom_bank), 0);
        check({name, "_out_valid"}, longint'(out_valid), 0);
        check({name, "_out_data"}, longint'(out_data), 0);
    endtask

    // Offers a set, waits for the result, checks it, then completes the handshake.
    task automatic run_set(input string name, input int mode,
                           input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input logic [DW-1:0] c, input logic [DW-1:0] d,
                           input longint exp, input int hold, input bit early);
        int cs_cnt;
        int guard;
        rom_mode = mode;
        guard = 0;
        while (!in_ready && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) check({name, "_ready_timeout"}, 0, 1);
        in_valid = 1'b1;
        x0 = a; x1 = b; x2 = c; x3 = d;
        out_ready = early;
        @(negedge clk);
        in_valid = 1'b0;
        cs_cnt = 0;
        guard = 0;
        while (!out_valid && guard < 40) begin
            if (rom_cs) cs_cnt++;
            @(negedge clk);
            guard++;
        end
        check({name, "_valid"}, longint'(out_valid), 1);
        check({name, "_data"}, longint'(out_data), exp);
        check({name, "_cs_cycles"}, cs_cnt, DW);
        if (!early) begin
            check({name, "_in_ready_done"}, longint'(in_ready), 0);
            repeat (hold) @(negedge clk);
            out_ready = 1'b1;
        end
        @(negedge clk);
        out_ready = 1'b0;
        check({name, "_idle_after"}, longint'({in_ready, out_valid}), 2);
    endtask

    typedef struct {
        string         name;
        int            mode;
        logic [DW-1:0] a, b, c, d;
        longint        exp;
    } vec_t;

    vec_t vecs [9];

    initial begin
        vecs[0] = '{"const1_zero",  0, 12'h000, 12'h000, 12'h000, 12'h000, -1};
        vecs[1] = '{"bank_2047",    1, 12'h7FF, 12'h000, 12'h000, 12'h000, 2047};
        vecs[2] = '{"bank_m2048",   1, 12'h800, 12'h000, 12'h000, 12'h000, -2048};
        vecs[3] = '{"bank_m1",      1, 12'hFFF, 12'h000, 12'h000, 12'h000, -1};
        vecs[4] = '{"bank_5",       1, 12'h005, 12'hFFF, 12'h123, 12'h456, 5};
        vecs[5] = '{"real_zero",    2, 12'h000, 12'h000, 12'h000, 12'h000, -4926};
        vecs[6] = '{"real_all_m1",  2, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, -592};
        vecs[7] = '{"real_x0_m1",   2, 12'hFFF, 12'h000, 12'h000, 12'h000, -273};
        vecs[8] = '{"const1_mixed", 0, 12'h3A5, 12'h800, 12'h7FF, 12'h001, -1};

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        foreach (vecs[i])
            run_set(vecs[i].name, vecs[i].mode, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].d,
                    vecs[i].exp, 1, 1'b0);

        // Long stall in DONE with a competing set offered the whole time.
        begin
            int guard = 0;
            rom_mode = 2;
            in_valid = 1'b1;
            x0 = 12'h000; x1 = 12'h000; x2 = 12'h000; x3 = 12'h000;
            @(negedge clk);
            x0 = 12'hFFF; x1 = 12'hFFF; x2 = 12'hFFF; x3 = 12'hFFF;
            while (!out_valid && guard < 40) begin
                @(negedge clk);
                guard++;
            end
            for (int k = 0; k < 20; k++) begin
                check("stall_valid", longint'(out_valid), 1);
                check("stall_data", longint'(out_data), -4926);
                check("stall_in_ready", longint'(in_ready), 0);
                @(negedge clk);
            end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            check("stall_release_ready", longint'(in_ready), 1);
            @(negedge clk);
            in_valid = 1'b0;
            check("stall_second_accepted", longint'(rom_cs), 1);
            guard = 0;
            while (!out_valid && guard < 40) begin
                @(negedge clk);
                guard++;
            end
            check("stall_second_data", longint'(out_data), -592);
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end

        // Reset pulse six cycles into RUN, then a clean set.
        begin
            rom_mode = 2;
            in_valid = 1'b1;
            x0 = 12'h5A5; x1 = 12'h0F0; x2 = 12'hF0F; x3 = 12'h333;
            @(negedge clk);
            in_valid = 1'b0;
            repeat (5) @(negedge clk);
            check("mid_run_cs", longint'(rom_cs), 1);
            rst_n = 1'b0;
            #1;
            check_reset_outputs("mid_reset");
            @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
            check("post_reset_no_valid", longint'(out_valid), 0);
            run_set("post_reset", 2, 12'h5A5, 12'h0F0, 12'hF0F, 12'h333,
                    golden(2, 12'h5A5, 12'h0F0, 12'hF0F, 12'h333), 0, 1'b0);
        end

        // Random back-to-back sets with random handshake timing.
        for (int n = 0; n < 16; n++) begin
            logic [DW-1:0] ra, rb, rc, rd;
            ra = DW'($urandom); rb = DW'($urandom); rc = DW'($urandom); rd = DW'($urandom);
            run_set($sformatf("rand%0d", n), 2, ra, rb, rc, rd, golden(2, ra, rb, rc, rd),
                    int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
